panda_lsu: RTL and testbench
============================

PANDA_LSU -- requirements
Module: panda_lsu

Interface
REQ-001 Parameter Depth, default 64, RAM depth in 32-bit words (power of two, >= 2); AW = $clog2(Depth).
REQ-002 clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  in  1  core request valid.
REQ-005 req_ready_o  out  1  LSU accepts request this cycle.
REQ-006 req_we_i  in  1  1 = store, 0 = load.
REQ-007 req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr_i  in  32  byte address.
REQ-010 req_wdata_i  in  32  store data, right-aligned.
REQ-011 rsp_valid_o  out  1  one-cycle response pulse.
REQ-012 rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err_o  out  1  access rejected; valid with rsp_valid_o.
REQ-014 ram_ce_o  out  1  RAM chip enable.
REQ-015 ram_we_o  out  4  RAM byte write enables.
REQ-016 ram_addr_o  out  AW  RAM word address.
REQ-017 ram_data_o  out  32  RAM write data.
REQ-018 ram_data_i  in  32  RAM read data, valid the cycle after a ce with we = 0.

Function
REQ-019 FSM states IDLE, RD1, RD2, WR2; req_ready_o = (state == IDLE).
REQ-020 Accept = req_valid_i & req_ready_o; address, size, unsigned, wdata, offset o = addr[1:0] captured on accept.
REQ-021 Error on accept if size = 11, addr >= 4*Depth, or misaligned access not handled per REQ-035/036; errors make no RAM access, give rsp_valid_o = rsp_err_o = 1 next cycle, state stays IDLE.
REQ-022 RAM outputs driven combinationally in the accept cycle for beat 1, from registers for beat 2; ram_ce_o = 0, ram_we_o = 0, ram_data_o = 0 when no beat is issued.
REQ-023 Lane rule: 64-bit data = {32'b0, wdata} << 8*o; 8-bit mask = sizemask (0001/0011/1111) << o; beat 1 (word w = addr[AW+1:2]) uses bits [31:0]/mask[3:0], beat 2 (word w+1) uses [63:32]/mask[7:4].
REQ-024 Aligned store: beat 1 in accept cycle N, rsp_valid_o at N+1, state stays IDLE (back-to-back stores, one per cycle).
REQ-025 Aligned load: beat 1 at N, state RD1 at N+1, ram_data_i registered and formatted, rsp_valid_o at N+2, IDLE at N+2.
REQ-026 Load formatting: ({hi, lo} >> 8*o), select low 8/16/32 bits, sign-extend from bit 7/15 unless req_unsigned_i; hi = 0 for aligned loads.
REQ-027 rsp_valid_o, rsp_rdata_o, rsp_err_o are registered; rsp_rdata_o/rsp_err_o return to 0 when rsp_valid_o = 0.
REQ-028 req_valid_i while not ready is ignored; no request queuing.
REQ-029 Stores with zero effective mask never occur (all legal sizes nonzero).

Reset
REQ-030 While rst_i = 1: state IDLE, all registers and outputs 0, including req_ready_o.
REQ-031 Reset mid-operation aborts the access; no response and no further RAM beat after reset release.
REQ-032 req_ready_o = 1 in the first cycle after rst_i deasserts.

Configuration
REQ-033 Macro PANDA_LSU_MISALIGNED_EN selects misaligned handling.
REQ-034 Misaligned: half with o = 3, word with o != 0 (spans two words).
REQ-035 Defined: misaligned store issues beat 1 at N, WR2 beat 2 at N+1, rsp at N+2; misaligned load issues beat 1 at N, RD1 issues beat 2 at N+1 capturing lo, RD2 captures hi at N+2, rsp at N+3; w = Depth-1 gives error.
REQ-036 Undefined: every misaligned access errors per REQ-021; states RD2/WR2 and hi capture register are absent.

Verification
REQ-037 Store word 0xABCDEF89 to addr 0xA0 -> N: ce=1, we=1111, ram_addr=40, data=0xABCDEF89; rsp_valid at N+1, err=0.
REQ-038 Store half 0xEF89 to addr 0xA6 -> we=1100, data=0xEF890000, ram_addr=41.
REQ-039 RAM word 5 = 0x80FF7F01; load byte addr 0x16 signed -> rdata 0xFFFFFFFF at N+2; unsigned addr 0x17 -> 0x00000080.
REQ-040 Load word addr 0x100 (Depth 64) -> no ce, rsp_err=1 at N+1; size 11 -> same.
REQ-041 With macro, words 2/3 = 0x44332211/0x88776655, load word addr 0x0A -> beats addr 2 then 3, rdata 0x66554433 at N+3; without macro -> err at N+1, no ce.
REQ-042 rst_i pulsed in RD1 -> no rsp_valid, ram_ce=0, ready=1 after release.

Source files
------------

// File: rtl/panda_lsu.sv
// panda_lsu: single-port load/store unit in front of a 32-bit word RAM.
// Handles byte/half/word loads and stores, including sign/zero extension
// and lane steering of store data and byte enables.
// Optional feature: define PANDA_LSU_MISALIGNED_EN to split accesses that
// cross a word boundary into two RAM beats. Without it they are errors.
module panda_lsu #(
  parameter int Depth = 64,
  localparam int AW = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_unsigned_i,
  input  logic [31:0]   req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          rsp_valid_o,
  output logic [31:0]   rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          ram_ce_o,
  output logic [3:0]    ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_data_o,
  input  logic [31:0]   ram_data_i
);

`ifdef PANDA_LSU_MISALIGNED_EN
  typedef enum logic [1:0] {IDLE, RD1, RD2, WR2} state_t;
`else
  typedef enum logic [0:0] {IDLE, RD1} state_t;
`endif

  state_t state, state_n;

  // captured request attributes
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          uns_q;
`ifdef PANDA_LSU_MISALIGNED_EN
  logic [AW-1:0] w_q;
  logic          misal_q;
  logic [3:0]    b2_we;
  logic [31:0]   b2_data;
  logic [31:0]   lo_q;
`endif

  // next response values
  logic          rsp_v_n, rsp_e_n;
  logic [31:0]   rsp_d_n;

  // request decode (used only in the accept cycle)
  logic          accept;
  logic [3:0]    smask;
  logic [7:0]    m8;
  logic [31:0]   lane_lo;
  logic [AW-1:0] w;
  logic          oor, misal, err;

  assign req_ready_o = (state == IDLE) & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;
  assign w           = req_addr_i[AW+1:2];
  assign oor         = |(req_addr_i >> (AW + 2));
  assign m8          = {4'b0000, smask} << req_addr_i[1:0];
  assign misal       = |m8[7:4];

`ifdef PANDA_LSU_MISALIGNED_EN
  logic [63:0] wide;
  logic [31:0] lane_hi;
  assign wide    = {32'b0, req_wdata_i} << {req_addr_i[1:0], 3'b000};
  assign lane_lo = wide[31:0];
  assign lane_hi = wide[63:32];
  // the second word of a split access would fall off the end of the RAM
  assign err     = (req_size_i == 2'b11) | oor | (misal & (&w));
`else
  assign lane_lo = req_wdata_i << {req_addr_i[1:0], 3'b000};
  assign err     = (req_size_i == 2'b11) | oor | misal;
`endif

  // byte-enable pattern for the access size before lane shifting
  always_comb begin
    case (req_size_i)
      2'b00:   smask = 4'b0001;
      2'b01:   smask = 4'b0011;
      2'b10:   smask = 4'b1111;
      default: smask = 4'b0000;
    endcase
  end

  // shift the two-word window down to the access offset, then extend
  function automatic logic [31:0] fmt(input logic [63:0] d, input logic [1:0] o,
                                      input logic [1:0] sz, input logic u);
    logic [31:0] s;
    s = 32'(d >> {o, 3'b000});
    case (sz)
      2'b00:   fmt = u ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   fmt = u ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: fmt = s;
    endcase
  endfunction

  // next state, RAM beat and response
  always_comb begin
    state_n    = state;
    ram_ce_o   = 1'b0;
    ram_we_o   = 4'b0000;
    ram_addr_o = '0;
    ram_data_o = 32'b0;
    rsp_v_n    = 1'b0;
    rsp_e_n    = 1'b0;
    rsp_d_n    = 32'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (err) begin
            rsp_v_n = 1'b1;
            rsp_e_n = 1'b1;
          end else begin
            ram_ce_o   = 1'b1;
            ram_addr_o = w;
            if (req_we_i) begin
              ram_we_o   = m8[3:0];
              ram_data_o = lane_lo;
`ifdef PANDA_LSU_MISALIGNED_EN
              if (misal) state_n = WR2;
              else       rsp_v_n = 1'b1;
`else
              rsp_v_n = 1'b1;
`endif
            end else begin
              state_n = RD1;
            end
          end
        end
      end
      RD1: begin
`ifdef PANDA_LSU_MISALIGNED_EN
        if (misal_q) begin
          ram_ce_o   = 1'b1;
          ram_addr_o = w_q + AW'(1);
          state_n    = RD2;
        end else
`endif
        begin
          rsp_v_n = 1'b1;
          rsp_d_n = fmt({32'b0, ram_data_i}, off_q, size_q, uns_q);
          state_n = IDLE;
        end
      end
`ifdef PANDA_LSU_MISALIGNED_EN
      RD2: begin
        rsp_v_n = 1'b1;
        rsp_d_n = fmt({ram_data_i, lo_q}, off_q, size_q, uns_q);
        state_n = IDLE;
      end
      WR2: begin
        ram_ce_o   = 1'b1;
        ram_addr_o = w_q + AW'(1);
        ram_we_o   = b2_we;
        ram_data_o = b2_data;
        rsp_v_n    = 1'b1;
        state_n    = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // capture request attributes on accept, and the low word of a split load
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      off_q   <= 2'b0;
      size_q  <= 2'b0;
      uns_q   <= 1'b0;
`ifdef PANDA_LSU_MISALIGNED_EN
      w_q     <= '0;
      misal_q <= 1'b0;
      b2_we   <= 4'b0;
      b2_data <= 32'b0;
      lo_q    <= 32'b0;
`endif
    end else begin
      if (accept) begin
        off_q   <= req_addr_i[1:0];
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
`ifdef PANDA_LSU_MISALIGNED_EN
        w_q     <= w;
        misal_q <= misal;
        b2_we   <= req_we_i ? m8[7:4] : 4'b0;
        b2_data <= req_we_i ? lane_hi : 32'b0;
`endif
      end
`ifdef PANDA_LSU_MISALIGNED_EN
      if (state == RD1) lo_q <= ram_data_i;
`endif
    end
  end

  // registered response; data and error are zero whenever valid is low
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'b0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= rsp_v_n;
      rsp_rdata_o <= rsp_d_n;
      rsp_err_o   <= rsp_e_n;
    end
  end

endmodule

// File: tb/tb_panda_lsu.sv
// Directed bench for panda_lsu with a behavioural byte-enabled RAM.
module tb_panda_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_ce;
  logic [3:0]  ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata = 32'b0;
  logic [31:0] mem [64];
  int          n_chk = 0, n_pass = 0;

  panda_lsu #(.Depth(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'b0;

  always @(posedge clk) begin
    if (ram_ce) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic put(input logic we, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    #1;
  endtask

  task automatic drop();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] xwe,
                       input logic [5:0] xaddr, input logic [31:0] xdata);
    put(1'b1, sz, 1'b0, a, d);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".ce"},    32'(ram_ce), 32'd1);
    chk({tag, ".we"},    32'(ram_we), 32'(xwe));
    chk({tag, ".addr"},  32'(ram_addr), 32'(xaddr));
    chk({tag, ".data"},  ram_wdata, xdata);
    drop();
    chk({tag, ".rsp"},   {rsp_valid, rsp_err}, 32'b10);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [5:0] xaddr, input logic [31:0] xd);
    put(1'b0, sz, u, a, 32'b0);
    chk({tag, ".ce"},   {ram_ce, ram_we}, 32'b10000);
    chk({tag, ".addr"}, 32'(ram_addr), 32'(xaddr));
    drop();
    chk({tag, ".busy"}, {rsp_valid, req_ready}, 32'b00);
    @(negedge clk); #1;
    chk({tag, ".rsp"},  {rsp_valid, rsp_err}, 32'b10);
    chk({tag, ".data"}, rsp_rdata, xd);
  endtask

  task automatic bad(input string tag, input logic we, input logic [1:0] sz,
                     input logic [31:0] a);
    put(we, sz, 1'b0, a, 32'h1234_5678);
    chk({tag, ".noce"}, {ram_ce, ram_we}, 32'b0);
    drop();
    chk({tag, ".err"},  {rsp_valid, rsp_err}, 32'b11);
    chk({tag, ".data"}, rsp_rdata, 32'b0);
  endtask

  initial begin
    // reset state
    @(negedge clk); #1;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.ce",    32'(ram_ce), 32'd0);
    chk("rst.rsp",   {rsp_valid, rsp_err, rsp_rdata[0]}, 32'b0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rel.ready", 32'(req_ready), 32'd1);

    // aligned stores
    store("st_word", 2'b10, 32'hA0, 32'hABCD_EF89, 4'b1111, 6'd40, 32'hABCD_EF89);
    store("st_half", 2'b01, 32'hA6, 32'h0000_EF89, 4'b1100, 6'd41, 32'hEF89_0000);
    store("st_byte", 2'b00, 32'h11, 32'h0000_00C3, 4'b0010, 6'd4,  32'h0000_C300);
    store("st_w5",   2'b10, 32'h14, 32'h80FF_7F01, 4'b1111, 6'd5,  32'h80FF_7F01);

    // back-to-back stores, one per cycle
    put(1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_2222);
    chk("b2b.ce0", {ram_ce, 26'b0, ram_addr}, {1'b1, 26'b0, 6'd8});
    put(1'b1, 2'b10, 1'b0, 32'h24, 32'h3333_4444);
    chk("b2b.ce1", {ram_ce, req_ready, 24'b0, ram_addr}, {2'b11, 24'b0, 6'd9});
    chk("b2b.rsp0", 32'(rsp_valid), 32'd1);
    drop();
    chk("b2b.rsp1", 32'(rsp_valid), 32'd1);

    // aligned loads and extension
    load("ld_b_s",  2'b00, 1'b0, 32'h16, 6'd5,  32'hFFFF_FFFF);
    load("ld_b_u",  2'b00, 1'b1, 32'h17, 6'd5,  32'h0000_0080);
    load("ld_h_s",  2'b01, 1'b0, 32'h16, 6'd5,  32'hFFFF_80FF);
    load("ld_h_lo", 2'b01, 1'b0, 32'h14, 6'd5,  32'h0000_7F01);
    load("ld_w40",  2'b10, 1'b0, 32'hA0, 6'd40, 32'hABCD_EF89);
    load("ld_w41",  2'b10, 1'b0, 32'hA4, 6'd41, 32'hEF89_0000);
    load("ld_b4",   2'b00, 1'b1, 32'h11, 6'd4,  32'h0000_00C3);
    load("ld_w9",   2'b10, 1'b0, 32'h24, 6'd9,  32'h3333_4444);
    @(negedge clk); #1;
    chk("idle.rsp", {rsp_valid, rsp_err, 30'b0}, 32'b0);

    // errors
    bad("e_oor",   1'b0, 2'b10, 32'h100);
    bad("e_size",  1'b0, 2'b11, 32'h0);
    bad("e_st_oor",1'b1, 2'b10, 32'h200);
    bad("e_last",  1'b0, 2'b10, 32'hFD);
    load("ld_w9b",  2'b10, 1'b0, 32'h24, 6'd9,  32'h3333_4444);

    // misaligned accesses
    store("st_w2", 2'b10, 32'h08, 32'h4433_2211, 4'b1111, 6'd2, 32'h4433_2211);
    store("st_w3", 2'b10, 32'h0C, 32'h8877_6655, 4'b1111, 6'd3, 32'h8877_6655);
    load("ld_h_a", 2'b01, 1'b1, 32'h0A, 6'd2, 32'h0000_4433);
`ifdef PANDA_LSU_MISALIGNED_EN
    put(1'b0, 2'b10, 1'b0, 32'h0A, 32'b0);
    chk("mis_ld.b1", {ram_ce, ram_we, 21'b0, ram_addr}, {1'b1, 4'b0, 21'b0, 6'd2});
    drop();
    chk("mis_ld.b2", {ram_ce, ram_we, 21'b0, ram_addr}, {1'b1, 4'b0, 21'b0, 6'd3});
    @(negedge clk); #1;
    chk("mis_ld.wait", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    chk("mis_ld.rsp",  {rsp_valid, rsp_err}, 32'b10);
    chk("mis_ld.data", rsp_rdata, 32'h6655_4433);
    put(1'b1, 2'b10, 1'b0, 32'h31, 32'hCAFE_BABE);
    chk("mis_st.b1", {ram_we, 22'b0, ram_addr}, {4'b1110, 22'b0, 6'd12});
    chk("mis_st.d1", ram_wdata, 32'hFEBA_BE00);
    drop();
    chk("mis_st.b2", {ram_ce, ram_we, 21'b0, ram_addr}, {1'b1, 4'b0001, 21'b0, 6'd13});
    chk("mis_st.d2", ram_wdata, 32'h0000_00CA);
    chk("mis_st.wait", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    chk("mis_st.rsp", {rsp_valid, rsp_err}, 32'b10);
    chk("mis_st.mem", mem[13], 32'h0000_00CA);
`else
    bad("e_mis_w", 1'b0, 2'b10, 32'h0A);
    bad("e_mis_h", 1'b0, 2'b01, 32'h0F);
    bad("e_mis_st",1'b1, 2'b10, 32'h31);
`endif

    // reset while waiting for load data
    put(1'b0, 2'b10, 1'b0, 32'h14, 32'b0);
    drop();
    rst = 1'b1; #1;
    chk("rrd.ready", 32'(req_ready), 32'd0);
    chk("rrd.ce",    32'(ram_ce), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rrd.rel",   {req_ready, rsp_valid, ram_ce}, 32'b100);
    @(negedge clk); #1;
    chk("rrd.none",  {req_ready, rsp_valid, ram_ce}, 32'b100);
    @(negedge clk); #1;
    chk("rrd.none2", {rsp_valid, rsp_err, ram_ce}, 32'b000);
    load("ld_after", 2'b10, 1'b0, 32'h14, 6'd5, 32'h80FF_7F01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
